// File: rtl/pip_hzd_ctrl_rv32_if.sv
// Pipeline hazard-control bus: ID/EX/MEM/WB hazard inputs toward the controller,
// stall/flush/forward strobes and status back toward the pipeline.
interface pip_hzd_ctrl_rv32_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       iIDrs1ADDR;
  logic [4:0]       iIDrs2ADDR;
  logic             iIDrs1USE;
  logic             iIDrs2USE;
  logic             iIDvalid;
  logic [4:0]       iEXdregADDR;
  logic             iEXisLOAD;
  logic             iEXvalid;
  logic [4:0]       iMEMdregADDR;
  logic [4:0]       iWBdregADDR;
  logic             iMEMvalid;
  logic             iWBvalid;
  logic             iBRtaken;
  logic             iDMEMbusy;
  logic             iCNTclr;
  logic             oStallIF;
  logic             oStallID;
  logic             oStallEX;
  logic             oBubbleEX;
  logic             oFlushID;
  logic [1:0]       oFwdA;
  logic [1:0]       oFwdB;
  logic [1:0]       oState;
  logic [CNT_W-1:0] oStallCNT;

  modport master (
    output iIDrs1ADDR, iIDrs2ADDR, iIDrs1USE, iIDrs2USE, iIDvalid,
    output iEXdregADDR, iEXisLOAD, iEXvalid,
    output iMEMdregADDR, iWBdregADDR, iMEMvalid, iWBvalid,
    output iBRtaken, iDMEMbusy, iCNTclr,
    input  oStallIF, oStallID, oStallEX, oBubbleEX, oFlushID,
    input  oFwdA, oFwdB, oState, oStallCNT
  );

  modport slave (
    input  iIDrs1ADDR, iIDrs2ADDR, iIDrs1USE, iIDrs2USE, iIDvalid,
    input  iEXdregADDR, iEXisLOAD, iEXvalid,
    input  iMEMdregADDR, iWBdregADDR, iMEMvalid, iWBvalid,
    input  iBRtaken, iDMEMbusy, iCNTclr,
    output oStallIF, oStallID, oStallEX, oBubbleEX, oFlushID,
    output oFwdA, oFwdB, oState, oStallCNT
  );
endinterface

// File: rtl/pip_hzd_ctrl_rv32.sv
// RV32 5-stage hazard controller: load-use stall, branch flush, data-memory wait,
// operand forwarding selects and a saturating stall-cycle counter.
module pip_hzd_ctrl_rv32 #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                iCLK,
  input logic                iRSTn,
  pip_hzd_ctrl_rv32_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10,
    FLUSH   = 2'b11
  } state_t;

  localparam logic [2:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_t           state_q, state_d;
  state_t           resume_q, resume_d;
  state_t           eff_state;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             stall_if, stall_id, stall_ex, bubble_ex, flush_id;

  function automatic logic [1:0] fwd_sel(
    input logic       src_use,
    input logic [4:0] rs,
    input logic       ex_valid,
    input logic       ex_load,
    input logic [4:0] ex_rd,
    input logic       mem_valid,
    input logic [4:0] mem_rd,
    input logic       wb_valid,
    input logic [4:0] wb_rd
  );
    if (!src_use || rs == 5'd0)               return 2'b00;
    if (ex_valid && !ex_load && ex_rd == rs)  return 2'b01;
    if (mem_valid && mem_rd == rs)            return 2'b10;
    if (wb_valid && wb_rd == rs)              return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = bus.iIDvalid & bus.iEXvalid & bus.iEXisLOAD & (bus.iEXdregADDR != 5'd0) &
                    ((bus.iIDrs1USE & (bus.iIDrs1ADDR == bus.iEXdregADDR)) |
                     (bus.iIDrs2USE & (bus.iIDrs2ADDR == bus.iEXdregADDR)));

  always_comb begin
    // A memory wait is transparent: once it ends, the interrupted state's rules apply at once.
    eff_state = (state_q == MEMWAIT) ? resume_q : state_q;
    state_d   = state_q;
    resume_d  = resume_q;
    fcnt_d    = fcnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (bus.iDMEMbusy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      state_d  = MEMWAIT;
      if (state_q != MEMWAIT) resume_d = state_q;
    end else if (bus.iBRtaken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
      fcnt_d    = FCNT_INIT;
    end else begin
      case (eff_state)
        FLUSH: begin
          flush_id = 1'b1;
          if (fcnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
            fcnt_d  = fcnt_q - 3'd1;
          end
        end
        RUN: begin
          if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = LDSTALL;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (bus.iCNTclr)   stall_cnt_d = '0;
    else if (stall_if) stall_cnt_d = sat_inc(stall_cnt_q);
    else               stall_cnt_d = stall_cnt_q;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.oStallIF  = stall_if;
  assign bus.oStallID  = stall_id;
  assign bus.oStallEX  = stall_ex;
  assign bus.oBubbleEX = bubble_ex;
  assign bus.oFlushID  = flush_id;
  assign bus.oFwdA     = fwd_sel(bus.iIDrs1USE, bus.iIDrs1ADDR, bus.iEXvalid, bus.iEXisLOAD,
                                 bus.iEXdregADDR, bus.iMEMvalid, bus.iMEMdregADDR,
                                 bus.iWBvalid, bus.iWBdregADDR);
  assign bus.oFwdB     = fwd_sel(bus.iIDrs2USE, bus.iIDrs2ADDR, bus.iEXvalid, bus.iEXisLOAD,
                                 bus.iEXdregADDR, bus.iMEMvalid, bus.iMEMdregADDR,
                                 bus.iWBvalid, bus.iWBdregADDR);
  assign bus.oState    = state_q;
  assign bus.oStallCNT = stall_cnt_q;

endmodule

// File: tb/tb_pip_hzd_ctrl_rv32.sv
// Directed bench for pip_hzd_ctrl_rv32 with a cycle-level behavioural model.
module tb_pip_hzd_ctrl_rv32;
  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int M_RUN = 0;
  localparam int M_LD  = 1;
  localparam int M_FL  = 3;

  logic iCLK = 1'b0;
  logic iRSTn;
  int   checks   = 0;
  int   failures = 0;

  // Model: current mode, whether a memory wait is in progress, flush cycles still owed, stall count.
  int m_mode = M_RUN;
  bit m_wait = 0;
  int m_left = 0;
  int m_cnt  = 0;

  always #5 iCLK = ~iCLK;

  pip_hzd_ctrl_rv32_if #(.CNT_W(CW)) bus ();

  pip_hzd_ctrl_rv32 #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .bus  (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_load_use();
    return bus.iIDvalid && bus.iEXvalid && bus.iEXisLOAD && bus.iEXdregADDR != 5'd0 &&
           ((bus.iIDrs1USE && bus.iIDrs1ADDR == bus.iEXdregADDR) ||
            (bus.iIDrs2USE && bus.iIDrs2ADDR == bus.iEXdregADDR));
  endfunction

  function automatic int m_fwd(input logic u, input logic [4:0] rs);
    logic       vld [3];
    logic [4:0] dst [3];
    if (!u || rs == 5'd0) return 0;
    vld[0] = bus.iEXvalid && !bus.iEXisLOAD; dst[0] = bus.iEXdregADDR;
    vld[1] = bus.iMEMvalid;                  dst[1] = bus.iMEMdregADDR;
    vld[2] = bus.iWBvalid;                   dst[2] = bus.iWBdregADDR;
    for (int k = 0; k < 3; k++)
      if (vld[k] && dst[k] == rs) return k + 1;
    return 0;
  endfunction

  always @(negedge iCLK) begin : cmp
    bit e_sif, e_sid, e_sex, e_bub, e_fl;
    int e_st, nx_mode, nx_left;
    bit nx_wait;
    if (!iRSTn) begin
      m_mode = M_RUN; m_wait = 0; m_left = 0; m_cnt = 0;
    end
    e_sif = 0; e_sid = 0; e_sex = 0; e_bub = 0; e_fl = 0;
    nx_mode = m_mode; nx_wait = m_wait; nx_left = m_left;
    if (bus.iDMEMbusy) begin
      e_sif = 1; e_sid = 1; e_sex = 1; nx_wait = 1;
    end else begin
      nx_wait = 0;
      if (bus.iBRtaken) begin
        e_fl = 1; e_bub = 1; nx_left = FC - 1;
        nx_mode = (nx_left > 0) ? M_FL : M_RUN;
      end else if (m_mode == M_FL) begin
        e_fl = 1; nx_left = m_left - 1;
        if (nx_left == 0) nx_mode = M_RUN;
      end else if (m_mode == M_LD) begin
        nx_mode = M_RUN;
      end else if (m_load_use()) begin
        e_sif = 1; e_sid = 1; e_bub = 1; nx_mode = M_LD;
      end
    end
    e_st = m_wait ? 2 : m_mode;
    chk("cyc_stallIF",  bus.oStallIF,  e_sif);
    chk("cyc_stallID",  bus.oStallID,  e_sid);
    chk("cyc_stallEX",  bus.oStallEX,  e_sex);
    chk("cyc_bubbleEX", bus.oBubbleEX, e_bub);
    chk("cyc_flushID",  bus.oFlushID,  e_fl);
    chk("cyc_fwdA",     bus.oFwdA,     m_fwd(bus.iIDrs1USE, bus.iIDrs1ADDR));
    chk("cyc_fwdB",     bus.oFwdB,     m_fwd(bus.iIDrs2USE, bus.iIDrs2ADDR));
    chk("cyc_state",    bus.oState,    e_st);
    chk("cyc_stallcnt", bus.oStallCNT, m_cnt);
    if (iRSTn) begin
      m_mode = nx_mode; m_wait = nx_wait; m_left = nx_left;
      if (bus.iCNTclr)  m_cnt = 0;
      else if (e_sif)   m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
  end

  task automatic idle();
    bus.iIDrs1ADDR = 5'd0; bus.iIDrs2ADDR = 5'd0; bus.iIDrs1USE = 1'b0; bus.iIDrs2USE = 1'b0;
    bus.iIDvalid = 1'b0; bus.iEXdregADDR = 5'd0; bus.iEXisLOAD = 1'b0; bus.iEXvalid = 1'b0;
    bus.iMEMdregADDR = 5'd0; bus.iWBdregADDR = 5'd0; bus.iMEMvalid = 1'b0; bus.iWBvalid = 1'b0;
    bus.iBRtaken = 1'b0; bus.iDMEMbusy = 1'b0; bus.iCNTclr = 1'b0;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_load_use_x5();
    bus.iEXvalid = 1'b1; bus.iEXisLOAD = 1'b1; bus.iEXdregADDR = 5'd5;
    bus.iIDvalid = 1'b1; bus.iIDrs1USE = 1'b1; bus.iIDrs1ADDR = 5'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    iRSTn = 1'b0;
    idle();
    tick();
    settle();
    chk("rst_state", bus.oState, 0);
    chk("rst_cnt", bus.oStallCNT, 0);
    chk("rst_stallIF", bus.oStallIF, 0);
    chk("rst_flushID", bus.oFlushID, 0);
    tick();
    iRSTn = 1'b1;

    // Load-use on x5, then the load forwards from MEM
    set_load_use_x5();
    settle();
    chk("lu_stallIF", bus.oStallIF, 1);
    chk("lu_stallID", bus.oStallID, 1);
    chk("lu_bubble", bus.oBubbleEX, 1);
    chk("lu_stallEX", bus.oStallEX, 0);
    tick();
    bus.iEXvalid = 1'b0; bus.iEXisLOAD = 1'b0;
    bus.iMEMvalid = 1'b1; bus.iMEMdregADDR = 5'd5;
    settle();
    chk("lu_ldstall_state", bus.oState, 1);
    chk("lu_ldstall_nostall", bus.oStallIF, 0);
    chk("lu_fwdA_mem", bus.oFwdA, 2);
    tick();
    idle();
    settle();
    chk("lu_back_run", bus.oState, 0);
    chk("lu_cnt_one", bus.oStallCNT, 1);
    tick();

    // LDSTALL ignores a load-use still present
    set_load_use_x5();
    settle();
    chk("sup_first", bus.oStallIF, 1);
    tick();
    settle();
    chk("sup_ldstall", bus.oStallIF, 0);
    tick();
    settle();
    chk("sup_again", bus.oStallIF, 1);
    tick();
    idle();
    tick();

    // Branch flush, FLUSH_CYCLES=2
    bus.iBRtaken = 1'b1;
    settle();
    chk("br_flush0", bus.oFlushID, 1);
    chk("br_bubble0", bus.oBubbleEX, 1);
    tick();
    bus.iBRtaken = 1'b0;
    settle();
    chk("br_state_fl", bus.oState, 3);
    chk("br_flush1", bus.oFlushID, 1);
    chk("br_bubble1", bus.oBubbleEX, 0);
    tick();
    settle();
    chk("br_state_run", bus.oState, 0);
    chk("br_flush2", bus.oFlushID, 0);
    tick();

    // Memory wait inside FLUSH with fcnt=0
    bus.iBRtaken = 1'b1;
    tick();
    bus.iBRtaken = 1'b0;
    bus.iDMEMbusy = 1'b1;
    settle();
    chk("mw_in_flush_state", bus.oState, 3);
    chk("mw_stallEX", bus.oStallEX, 1);
    chk("mw_noflush", bus.oFlushID, 0);
    tick();
    settle();
    chk("mw_state2", bus.oState, 2);
    chk("mw_noflush2", bus.oFlushID, 0);
    tick();
    settle();
    chk("mw_stallID3", bus.oStallID, 1);
    tick();
    bus.iDMEMbusy = 1'b0;
    settle();
    chk("mw_resume_flush", bus.oFlushID, 1);
    chk("mw_resume_nostall", bus.oStallIF, 0);
    tick();
    settle();
    chk("mw_run", bus.oState, 0);
    tick();

    // Forwarding priority
    idle();
    bus.iEXvalid = 1'b1; bus.iEXdregADDR = 5'd7;
    bus.iMEMvalid = 1'b1; bus.iMEMdregADDR = 5'd7;
    bus.iWBvalid = 1'b1; bus.iWBdregADDR = 5'd7;
    bus.iIDrs1USE = 1'b1; bus.iIDrs1ADDR = 5'd7;
    settle();
    chk("fwd_ex", bus.oFwdA, 1);
    tick();
    bus.iEXisLOAD = 1'b1;
    settle();
    chk("fwd_skip_load", bus.oFwdA, 2);
    tick();
    bus.iMEMvalid = 1'b0;
    settle();
    chk("fwd_wb", bus.oFwdA, 3);
    tick();
    bus.iIDrs1ADDR = 5'd0;
    bus.iIDrs2USE = 1'b1; bus.iIDrs2ADDR = 5'd7; bus.iEXisLOAD = 1'b0;
    settle();
    chk("fwd_x0", bus.oFwdA, 0);
    chk("fwdB_ex", bus.oFwdB, 1);
    tick();
    bus.iIDrs2USE = 1'b0;
    settle();
    chk("fwdB_unused", bus.oFwdB, 0);
    tick();
    idle();

    // Busy and branch together
    bus.iDMEMbusy = 1'b1; bus.iBRtaken = 1'b1;
    settle();
    chk("bb_stallIF", bus.oStallIF, 1);
    chk("bb_noflush", bus.oFlushID, 0);
    chk("bb_nobubble", bus.oBubbleEX, 0);
    tick();
    settle();
    chk("bb_state2", bus.oState, 2);
    tick();
    bus.iDMEMbusy = 1'b0;
    settle();
    chk("bb_flush", bus.oFlushID, 1);
    chk("bb_bubble", bus.oBubbleEX, 1);
    tick();
    bus.iBRtaken = 1'b0;
    settle();
    chk("bb_state_fl", bus.oState, 3);
    tick();
    settle();
    chk("bb_run", bus.oState, 0);
    tick();

    // Counter saturation and clear
    bus.iCNTclr = 1'b1;
    tick();
    bus.iCNTclr = 1'b0;
    settle();
    chk("cnt_cleared", bus.oStallCNT, 0);
    bus.iDMEMbusy = 1'b1;
    repeat (20) tick();
    settle();
    chk("cnt_sat", bus.oStallCNT, 15);
    bus.iCNTclr = 1'b1;
    tick();
    bus.iCNTclr = 1'b0;
    settle();
    chk("cnt_clr_wins", bus.oStallCNT, 0);
    tick();
    settle();
    chk("cnt_resume", bus.oStallCNT, 1);
    bus.iDMEMbusy = 1'b0;
    tick();
    settle();
    chk("cnt_run", bus.oState, 0);
    tick();

    // Asynchronous reset mid-FLUSH
    bus.iBRtaken = 1'b1;
    tick();
    bus.iBRtaken = 1'b0;
    #1;
    chk("ar_in_flush", bus.oState, 3);
    iRSTn = 1'b0;
    #1;
    chk("ar_state_async", bus.oState, 0);
    chk("ar_cnt_async", bus.oStallCNT, 0);
    tick();
    iRSTn = 1'b1;
    set_load_use_x5();
    settle();
    chk("ar_run_behaviour", bus.oStallIF, 1);
    chk("ar_noflush", bus.oFlushID, 0);
    tick();
    idle();
    tick();

    // Asynchronous reset mid-MEMWAIT
    bus.iDMEMbusy = 1'b1;
    tick();
    #1;
    chk("ar_in_memwait", bus.oState, 2);
    iRSTn = 1'b0;
    bus.iDMEMbusy = 1'b0;
    #1;
    chk("ar_mw_state", bus.oState, 0);
    chk("ar_mw_nostall", bus.oStallIF, 0);
    tick();
    iRSTn = 1'b1;
    settle();
    chk("ar_mw_run", bus.oState, 0);
    chk("ar_mw_noflush", bus.oFlushID, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pip_hzd_ctrl_rv32.md
PIP_HZD_CTRL_RV32 -- requirements
Module: pip_hzd_ctrl_rv32

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles the IF/ID stage is killed after a taken branch (legal 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the stall performance counter width.
REQ-003 The block SHALL have port iCLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRSTn  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports iIDrs1ADDR, iIDrs2ADDR  in  5 each  the source register addresses of the instruction in ID.
REQ-006 The block SHALL have ports iIDrs1USE, iIDrs2USE, iIDvalid  in  1 each  the source-used flags and the ID-valid flag.
REQ-007 The block SHALL have ports iEXdregADDR  in  5, plus iEXisLOAD and iEXvalid  in  1 each  the EX destination, a load-in-EX flag and the EX-valid flag.
REQ-008 The block SHALL have ports iMEMdregADDR and iWBdregADDR  in  5 each, plus iMEMvalid and iWBvalid  in  1 each  the MEM/WB destinations and their valid flags.
REQ-009 The block SHALL have ports iBRtaken  in  1 (EX-stage redirect), iDMEMbusy  in  1 (data memory not ready) and iCNTclr  in  1 (synchronous counter clear).
REQ-010 The block SHALL have ports oStallIF, oStallID, oStallEX, oBubbleEX, oFlushID  out  1 each  the pipeline control strobes.
REQ-011 The block SHALL have ports oFwdA, oFwdB  out  2 each  the operand source select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-012 The block SHALL have ports oState  out  2 and oStallCNT  out  CNT_W  the current FSM state and the stall-cycle count.

Function
REQ-013 The block SHALL hold registered state only in: the FSM state, a 3-bit flush counter fcnt, a 2-bit resume register and oStallCNT; all control and forwarding outputs SHALL be combinational (Mealy) functions of that state and the current inputs.
REQ-014 The FSM SHALL use the encodings RUN=00, LDSTALL=01, MEMWAIT=10, FLUSH=11, and oState SHALL equal the current state.
REQ-015 Condition priority, highest first, SHALL be: iDMEMbusy, then iBRtaken, then load-use, then none.
REQ-016 When iDMEMbusy=1 in any state: oStallIF=oStallID=oStallEX=1 and oBubbleEX=oFlushID=0; on entry from another state, resume SHALL capture the current state; the next state SHALL be MEMWAIT; fcnt SHALL be frozen.
REQ-017 In MEMWAIT with iDMEMbusy=0, the block SHALL apply the rules of the resume state in that same cycle and evaluate transitions as that state.
REQ-018 When iBRtaken=1 and iDMEMbusy=0: oFlushID=1 and oBubbleEX=1; if FLUSH_CYCLES=1 the next state SHALL be RUN, otherwise FLUSH with fcnt=FLUSH_CYCLES-2.
REQ-019 In FLUSH with no higher-priority event: oFlushID=1; if fcnt=0 the next state SHALL be RUN, otherwise fcnt SHALL decrement; a new iBRtaken SHALL restart the flush per REQ-018.
REQ-020 Load-use SHALL be defined as: iIDvalid & iEXvalid & iEXisLOAD & iEXdregADDR!=0 & ((iIDrs1USE & iIDrs1ADDR==iEXdregADDR) | (iIDrs2USE & iIDrs2ADDR==iEXdregADDR)).
REQ-021 Load-use in RUN SHALL produce oStallIF=oStallID=1 and oBubbleEX=1, with next state LDSTALL.
REQ-022 LDSTALL SHALL last exactly one cycle, SHALL suppress load-use detection and SHALL return to RUN unless a higher-priority event occurs.
REQ-023 Load-use SHALL be ignored in FLUSH.
REQ-024 oFwdA SHALL be 00 if !iIDrs1USE or iIDrs1ADDR=0; otherwise 01 if iEXvalid & !iEXisLOAD & iEXdregADDR==rs1; else 10 if iMEMvalid & iMEMdregADDR==rs1; else 11 if iWBvalid & iWBdregADDR==rs1; else 00. The youngest stage SHALL win.
REQ-025 oFwdB SHALL follow the same rule as oFwdA using rs2.
REQ-026 oStallCNT SHALL increment by 1 on each cycle with oStallIF=1, SHALL saturate at all-ones, and SHALL clear when iCNTclr=1; clear SHALL win over increment.
REQ-027 All outputs not asserted by a rule above SHALL be 0.

Reset
REQ-028 When iRSTn=0, the block SHALL immediately set state=RUN, resume=RUN, fcnt=0 and oStallCNT=0, regardless of iCLK.
REQ-029 With no inputs asserted, all control outputs SHALL then be 0.
REQ-030 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon that operation, and the first cycle after release SHALL behave as RUN.

Verification
REQ-031 The bench SHALL cover: EX load to x5, ID rs1=x5 used -> one cycle oStallIF=oStallID=oBubbleEX=1, then LDSTALL, then RUN; the next cycle with the load in MEM gives oFwdA=10.
REQ-032 The bench SHALL cover: iBRtaken pulse with FLUSH_CYCLES=2 -> oFlushID=1 for exactly 2 cycles, oBubbleEX=1 for the first cycle only, then state RUN.
REQ-033 The bench SHALL cover: iDMEMbusy held 3 cycles during FLUSH (fcnt=0) -> all stalls=1 and oFlushID=0 for 3 cycles, then one more FLUSH cycle, then RUN.
REQ-034 The bench SHALL cover: rs1=x7 with EX, MEM and WB all writing x7 (EX non-load) -> oFwdA=01; with rs1=x0 -> oFwdA=00.
REQ-035 The bench SHALL cover: iDMEMbusy=1 and iBRtaken=1 together -> stalls asserted and no flush; when busy drops with iBRtaken=1 -> flush begins.
REQ-036 The bench SHALL cover: CNT_W=4 with 20 stall cycles -> oStallCNT=15; iCNTclr asserted during a stall -> 0; iRSTn low mid-FLUSH -> oState=00 asynchronously.
